// File: rtl/ps2_packet_rx.sv
// PS/2 device-to-host packet receiver, sampled entirely in the clk domain.
// Synchronises and filters kclk/kdata, checks each frame and assembles PKT_BYTES frames per packet.
module ps2_packet_rx #(
    parameter int PKT_BYTES   = 3,
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int SYNC_CHECK  = 1,
    parameter int DEDUP       = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   kclk,
    input  logic                   kdata,
    output logic [8*PKT_BYTES-1:0] pkt_data,
    output logic                   pkt_valid,
    output logic                   frame_err,
    output logic [1:0]             err_code,
    output logic                   busy
);
    localparam int FCW = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    localparam int BIW = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    function automatic logic odd_par_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    logic           r_kclk_m, r_kclk_s, r_kclk_f, r_kclk_fd;
    logic           r_kdata_m, r_kdata_s, r_kdata_f;
    logic [FCW-1:0] r_kclk_cnt, r_kdata_cnt;

    // Two-flop synchronisers and run-length filters; filtered lines reset high (idle bus).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kclk_m    <= 1'b1;
            r_kclk_s    <= 1'b1;
            r_kclk_f    <= 1'b1;
            r_kclk_fd   <= 1'b1;
            r_kclk_cnt  <= {FCW{1'b0}};
            r_kdata_m   <= 1'b1;
            r_kdata_s   <= 1'b1;
            r_kdata_f   <= 1'b1;
            r_kdata_cnt <= {FCW{1'b0}};
        end else begin
            r_kclk_m  <= kclk;
            r_kclk_s  <= r_kclk_m;
            r_kclk_fd <= r_kclk_f;
            r_kdata_m <= kdata;
            r_kdata_s <= r_kdata_m;
            if (r_kclk_s == r_kclk_f) begin
                r_kclk_cnt <= {FCW{1'b0}};
            end else if (r_kclk_cnt == FCW'(FILT_LEN - 1)) begin
                r_kclk_f   <= r_kclk_s;
                r_kclk_cnt <= {FCW{1'b0}};
            end else begin
                r_kclk_cnt <= r_kclk_cnt + FCW'(1);
            end
            if (r_kdata_s == r_kdata_f) begin
                r_kdata_cnt <= {FCW{1'b0}};
            end else if (r_kdata_cnt == FCW'(FILT_LEN - 1)) begin
                r_kdata_f   <= r_kdata_s;
                r_kdata_cnt <= {FCW{1'b0}};
            end else begin
                r_kdata_cnt <= r_kdata_cnt + FCW'(1);
            end
        end
    end

    state_t                 r_state, w_state_nxt;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic                   r_par;
    logic [BIW-1:0]         r_byte_idx;
    logic [8*PKT_BYTES-1:0] r_bytes, r_hist, w_pkt_nxt;
    logic                   r_hist_vld;
    logic [TCW-1:0]         r_to_cnt;
    logic                   w_fall, w_timeout, w_sync_bad, w_last, w_dup;

    assign w_fall     = r_kclk_fd & ~r_kclk_f;
    assign w_timeout  = ~w_fall & (r_to_cnt == TCW'(TIMEOUT_CYC));
    assign w_sync_bad = (SYNC_CHECK != 0) && (r_byte_idx == {BIW{1'b0}}) && !r_shift[3];
    assign w_last     = (r_byte_idx == BIW'(PKT_BYTES - 1));
    assign w_dup      = (DEDUP != 0) && r_hist_vld && (w_pkt_nxt == r_hist);
    assign busy       = (r_state != S_IDLE) || (r_byte_idx != {BIW{1'b0}});

    // Packet image with the byte under evaluation dropped into its slot.
    always_comb begin
        w_pkt_nxt = r_bytes;
        w_pkt_nxt[{r_byte_idx, 3'b000} +: 8] = r_shift;
    end

    // Frame FSM next state: moves only on kclk falls, timeout forces IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   w_state_nxt = r_kdata_f ? S_IDLE : S_DATA;
                S_DATA:   w_state_nxt = (r_bit_cnt == 3'd7) ? S_PARITY : S_DATA;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP:   w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame datapath, packet assembly, timeout and registered result pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_par      <= 1'b0;
            r_byte_idx <= {BIW{1'b0}};
            r_bytes    <= {(8*PKT_BYTES){1'b0}};
            r_hist     <= {(8*PKT_BYTES){1'b0}};
            r_hist_vld <= 1'b0;
            r_to_cnt   <= {TCW{1'b0}};
            pkt_data   <= {(8*PKT_BYTES){1'b0}};
            pkt_valid  <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= 2'd0;
        end else begin
            pkt_valid <= 1'b0;
            frame_err <= 1'b0;
            if (w_fall || w_timeout || (r_state == S_IDLE && r_byte_idx == {BIW{1'b0}})) begin
                r_to_cnt <= {TCW{1'b0}};
            end else begin
                r_to_cnt <= r_to_cnt + TCW'(1);
            end
            if (w_timeout) begin
                r_byte_idx <= {BIW{1'b0}};
                frame_err  <= 1'b1;
                err_code   <= 2'd2;
            end else if (w_fall) begin
                case (r_state)
                    S_IDLE: r_bit_cnt <= 3'd0;
                    S_DATA: begin
                        r_shift   <= {r_kdata_f, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    S_PARITY: r_par <= r_kdata_f;
                    S_STOP: begin
                        if (!odd_par_ok(r_shift, r_par)) begin
                            frame_err  <= 1'b1;
                            err_code   <= 2'd0;
                            r_byte_idx <= {BIW{1'b0}};
                        end else if (!r_kdata_f) begin
                            frame_err  <= 1'b1;
                            err_code   <= 2'd1;
                            r_byte_idx <= {BIW{1'b0}};
                        end else if (w_sync_bad) begin
                            frame_err  <= 1'b1;
                            err_code   <= 2'd3;
                            r_byte_idx <= {BIW{1'b0}};
                        end else if (w_last) begin
                            r_byte_idx <= {BIW{1'b0}};
                            if (!w_dup) begin
                                pkt_data   <= w_pkt_nxt;
                                pkt_valid  <= 1'b1;
                                r_hist     <= w_pkt_nxt;
                                r_hist_vld <= 1'b1;
                            end
                        end else begin
                            r_bytes    <= w_pkt_nxt;
                            r_byte_idx <= r_byte_idx + BIW'(1);
                        end
                    end
                    default: r_bit_cnt <= 3'd0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_packet_rx.sv
// Scoreboard bench for ps2_packet_rx: three instances (mouse, dedup mouse, keyboard byte).
module tb_ps2_packet_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] kclk_v  = 3'b111;
    logic [2:0] kdata_v = 3'b111;
    logic [2:0] pv, fe, by;
    logic [1:0] ec0, ec1, ec2;
    logic [23:0] pd0, pd1;
    logic [7:0]  pd2;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic        is_err;
        logic [31:0] data;
        logic [1:0]  code;
    } exp_t;
    exp_t q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    ps2_packet_rx #(.PKT_BYTES(3), .FILT_LEN(4), .TIMEOUT_CYC(2000), .SYNC_CHECK(1), .DEDUP(0)) u_a (
        .clk(clk), .rst(rst), .kclk(kclk_v[0]), .kdata(kdata_v[0]), .pkt_data(pd0),
        .pkt_valid(pv[0]), .frame_err(fe[0]), .err_code(ec0), .busy(by[0]));
    ps2_packet_rx #(.PKT_BYTES(3), .FILT_LEN(4), .TIMEOUT_CYC(2000), .SYNC_CHECK(1), .DEDUP(1)) u_b (
        .clk(clk), .rst(rst), .kclk(kclk_v[1]), .kdata(kdata_v[1]), .pkt_data(pd1),
        .pkt_valid(pv[1]), .frame_err(fe[1]), .err_code(ec1), .busy(by[1]));
    ps2_packet_rx #(.PKT_BYTES(1), .FILT_LEN(4), .TIMEOUT_CYC(2000), .SYNC_CHECK(0), .DEDUP(0)) u_c (
        .clk(clk), .rst(rst), .kclk(kclk_v[2]), .kdata(kdata_v[2]), .pkt_data(pd2),
        .pkt_valid(pv[2]), .frame_err(fe[2]), .err_code(ec2), .busy(by[2]));

    function automatic logic [31:0] pd_of(input int i);
        case (i)
            0: return {8'h00, pd0};
            1: return {8'h00, pd1};
            default: return {24'h0, pd2};
        endcase
    endfunction

    function automatic logic [1:0] ec_of(input int i);
        case (i)
            0: return ec0;
            1: return ec1;
            default: return ec2;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int i, input logic is_err, input logic [31:0] data, input logic [1:0] code);
        exp_t e;
        e.is_err = is_err;
        e.data   = data;
        e.code   = code;
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic check_evt(input int i);
        exp_t e;
        logic got;
        got = 1'b0;
        e   = '0;
        case (i)
            0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
        endcase
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL unexpected_event inst%0d: pkt_valid=%0b frame_err=%0b data=0x%0h code=%0d, none expected",
                     i, pv[i], fe[i], pd_of(i), ec_of(i));
        end else if (pv[i]) begin
            if (e.is_err || pd_of(i) !== e.data) begin
                n_errors++;
                $display("FAIL packet inst%0d: got pkt 0x%0h, expected %s 0x%0h code %0d",
                         i, pd_of(i), e.is_err ? "error" : "pkt", e.data, e.code);
            end
        end else begin
            if (!e.is_err || ec_of(i) !== e.code) begin
                n_errors++;
                $display("FAIL error inst%0d: got err_code %0d, expected %s 0x%0h code %0d",
                         i, ec_of(i), e.is_err ? "error" : "pkt", e.data, e.code);
            end
        end
    endtask

    // Monitor: every output pulse pops one expected event from that instance's queue.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (pv[i] || fe[i]) check_evt(i);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input int i, input logic [10:0] bits, input int n, input bit glitch);
        for (int k = 0; k < n; k++) begin
            kdata_v[i] = bits[k];
            wait_cyc(10);
            kclk_v[i] = 1'b0;
            wait_cyc(20);
            kclk_v[i] = 1'b1;
            if (glitch && k == 3) begin
                wait_cyc(5);
                kclk_v[i] = 1'b0;
                wait_cyc(2);
                kclk_v[i] = 1'b1;
                wait_cyc(3);
            end else begin
                wait_cyc(10);
            end
        end
        kdata_v[i] = 1'b1;
    endtask

    task automatic send_frame(input int i, input logic [7:0] b, input bit bad_par, input bit glitch);
        logic p;
        p = ~(^b) ^ bad_par;
        send_bits(i, {1'b1, p, b, 1'b0}, 11, glitch);
    endtask

    initial begin
        wait_cyc(5);
        for (int i = 0; i < 3; i++) begin
            chk("rst_pkt_data", pd_of(i), 32'h0);
            chk("rst_pkt_valid", {31'h0, pv[i]}, 32'h0);
            chk("rst_frame_err", {31'h0, fe[i]}, 32'h0);
            chk("rst_err_code", {30'h0, ec_of(i)}, 32'h0);
            chk("rst_busy", {31'h0, by[i]}, 32'h0);
        end
        rst = 1'b0;
        wait_cyc(20);

        // Valid mouse packet
        push(0, 1'b0, 32'hFF0108, 2'd0);
        send_frame(0, 8'h08, 1'b0, 1'b0);
        send_frame(0, 8'h01, 1'b0, 1'b0);
        send_frame(0, 8'hFF, 1'b0, 1'b0);
        wait_cyc(20);
        chk("busy_after_pkt", {31'h0, by[0]}, 32'h0);

        // Parity error on byte 1, then a fresh packet
        send_frame(0, 8'h08, 1'b0, 1'b0);
        push(0, 1'b1, 32'h0, 2'd0);
        send_frame(0, 8'h01, 1'b1, 1'b0);
        push(0, 1'b0, 32'h030209, 2'd0);
        send_frame(0, 8'h09, 1'b0, 1'b0);
        send_frame(0, 8'h02, 1'b0, 1'b0);
        send_frame(0, 8'h03, 1'b0, 1'b0);

        // Sync failure leaves byte_idx at 0
        push(0, 1'b1, 32'h0, 2'd3);
        send_frame(0, 8'h00, 1'b0, 1'b0);
        wait_cyc(20);
        chk("busy_after_sync_err", {31'h0, by[0]}, 32'h0);

        // Timeout after two bytes, then a fresh packet
        send_frame(0, 8'h08, 1'b0, 1'b0);
        send_frame(0, 8'h01, 1'b0, 1'b0);
        chk("busy_mid_packet", {31'h0, by[0]}, 32'h1);
        push(0, 1'b1, 32'h0, 2'd2);
        wait_cyc(2005);
        chk("busy_after_timeout", {31'h0, by[0]}, 32'h0);
        push(0, 1'b0, 32'h0C0B0A, 2'd0);
        send_frame(0, 8'h0A, 1'b0, 1'b0);
        send_frame(0, 8'h0B, 1'b0, 1'b0);
        send_frame(0, 8'h0C, 1'b0, 1'b0);
        chk("err_code_held", {30'h0, ec0}, 32'h2);

        // Short kclk glitch inside a frame is ignored
        push(0, 1'b0, 32'h443308, 2'd0);
        send_frame(0, 8'h08, 1'b0, 1'b0);
        send_frame(0, 8'h33, 1'b0, 1'b1);
        send_frame(0, 8'h44, 1'b0, 1'b0);

        // Dedup instance
        push(1, 1'b0, 32'h201008, 2'd0);
        send_frame(1, 8'h08, 1'b0, 1'b0);
        send_frame(1, 8'h10, 1'b0, 1'b0);
        send_frame(1, 8'h20, 1'b0, 1'b0);
        send_frame(1, 8'h08, 1'b0, 1'b0);
        send_frame(1, 8'h10, 1'b0, 1'b0);
        send_frame(1, 8'h20, 1'b0, 1'b0);
        wait_cyc(20);
        chk("dedup_data_kept", pd_of(1), 32'h201008);
        push(1, 1'b0, 32'h201108, 2'd0);
        send_frame(1, 8'h08, 1'b0, 1'b0);
        send_frame(1, 8'h11, 1'b0, 1'b0);
        send_frame(1, 8'h20, 1'b0, 1'b0);

        // Single-byte keyboard instance
        push(2, 1'b0, 32'h1C, 2'd0);
        send_frame(2, 8'h1C, 1'b0, 1'b0);

        // Reset in the middle of a frame (start + 4 data bits)
        send_bits(0, 11'b000_1000_0000, 5, 1'b0);
        chk("busy_mid_frame", {31'h0, by[0]}, 32'h1);
        rst = 1'b1;
        #1;
        chk("midrst_pkt_data", pd_of(0), 32'h0);
        chk("midrst_err_code", {30'h0, ec0}, 32'h0);
        chk("midrst_busy", {31'h0, by[0]}, 32'h0);
        chk("midrst_flags", {30'h0, pv[0], fe[0]}, 32'h0);
        kclk_v  = 3'b111;
        kdata_v = 3'b111;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(20);
        push(0, 1'b0, 32'hFF0108, 2'd0);
        send_frame(0, 8'h08, 1'b0, 1'b0);
        send_frame(0, 8'h01, 1'b0, 1'b0);
        send_frame(0, 8'hFF, 1'b0, 1'b0);

        wait_cyc(100);
        chk("pending_inst0", q0.size(), 32'h0);
        chk("pending_inst1", q1.size(), 32'h0);
        chk("pending_inst2", q2.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
